// File: rtl/atm_arb_pkg.sv
// atm_arb_pkg
// Shared definitions for the ATM account arbiter: the session FSM state
// type and the default terminal count, field widths and watchdog limit.
package atm_arb_pkg;

  localparam int DEFAULT_NUM_ATM       = 4;
  localparam int DEFAULT_CARD_WIDTH    = 3;
  localparam int DEFAULT_BALANCE_WIDTH = 20;
  localparam int DEFAULT_HOLD_MAX      = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational rotating-priority search. Starting at rr_ptr and moving
// upward (wrapping at NUM_ATM), returns the first terminal with req set.
//   req    : per-terminal request vector
//   rr_ptr : terminal index that has highest priority this time
//   winner : index of the chosen terminal (0 when nothing is requested)
//   valid  : at least one request is present
module rr_picker
  import atm_arb_pkg::*;
#(
  parameter int NUM_ATM = DEFAULT_NUM_ATM,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_ATM-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Walk the terminals in priority order; the first hit is latched by the
  // valid flag so later hits in the same pass cannot overwrite it.
  always_comb begin : search
    int               idx;
    logic [IDX_W-1:0] idx_b;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_b  = '0;
    for (int k = 0; k < NUM_ATM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ATM) begin
        idx = idx - NUM_ATM;
      end
      idx_b = idx[IDX_W-1:0];
      if (!valid && req[idx_b]) begin
        valid  = 1'b1;
        winner = idx_b;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter
// Shares one card/account store between NUM_ATM terminals. One terminal at
// a time holds an exclusive session; its card number, balance and write
// strobe are routed to the store. A watchdog closes sessions that stall.
//   clk, rst         : clock and synchronous active-high reset
//   req              : per-terminal session request (level)
//   release_pulse    : per-terminal one-cycle session end ("release" is a
//                      reserved word, hence the longer name)
//   card_number      : packed card numbers, terminal i at [i*card_width +: card_width]
//   updated_balance  : packed balances, terminal i at [i*balance_width +: balance_width]
//   wr_en            : per-terminal balance write strobe
//   grant            : one-hot session grant
//   abort            : one-cycle pulse to a terminal whose session timed out
//   busy             : a session is open
//   acct_card, acct_balance, acct_we : store port driven by the session owner
module atm_account_arbiter
  import atm_arb_pkg::*;
#(
  parameter int NUM_ATM       = DEFAULT_NUM_ATM,
  parameter int card_width    = DEFAULT_CARD_WIDTH,
  parameter int balance_width = DEFAULT_BALANCE_WIDTH,
  parameter int HOLD_MAX      = DEFAULT_HOLD_MAX
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_ATM-1:0]               req,
  input  logic [NUM_ATM-1:0]               release_pulse,
  input  logic [NUM_ATM*card_width-1:0]    card_number,
  input  logic [NUM_ATM*balance_width-1:0] updated_balance,
  input  logic [NUM_ATM-1:0]               wr_en,
  output logic [NUM_ATM-1:0]               grant,
  output logic [NUM_ATM-1:0]               abort,
  output logic                             busy,
  output logic [card_width-1:0]            acct_card,
  output logic [balance_width-1:0]         acct_balance,
  output logic                             acct_we
);

  localparam int               IDX_W    = $clog2(NUM_ATM);
  localparam int               WD_W     = $clog2(HOLD_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ATM - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(HOLD_MAX);

  arb_state_t       state;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] search_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [WD_W-1:0]  wd_cnt;
  logic             session_drop;
  logic             session_expire;
  logic             in_grant;

  // Priority rotates to the terminal just after the last session owner.
  assign next_ptr = (winner == LAST_IDX) ? '0 : winner + 1'b1;

  // During RECOVER the pointer register has not been updated yet, so the
  // search already uses the rotated value; this lets a pending requester be
  // granted straight out of RECOVER, keeping the dead gap at one cycle.
  assign search_ptr = (state == ST_RECOVER) ? next_ptr : rr_ptr;

  rr_picker #(
    .NUM_ATM (NUM_ATM),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (search_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // A dropped request counts as a release, and a release beats expiry.
  assign session_drop   = release_pulse[winner] | ~req[winner];
  assign session_expire = (wd_cnt == WD_LIMIT);
  assign in_grant       = (state == ST_GRANT);

  // Store port follows the session owner combinationally and is parked at
  // zero whenever no session is open.
  always_comb begin
    acct_card    = '0;
    acct_balance = '0;
    acct_we      = 1'b0;
    if (in_grant) begin
      acct_card    = card_number[winner*card_width +: card_width];
      acct_balance = updated_balance[winner*balance_width +: balance_width];
      acct_we      = wr_en[winner];
    end
  end

  // Session FSM with registered grant/busy/abort. abort defaults low so it
  // can only ever be a single-cycle pulse during RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      winner <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
      grant  <= '0;
      abort  <= '0;
      busy   <= 1'b0;
    end else begin
      abort <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state  <= ST_GRANT;
            winner <= pick_idx;
            wd_cnt <= '0;
            grant  <= NUM_ATM'(1) << pick_idx;
            busy   <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (session_drop || session_expire) begin
            state <= ST_RECOVER;
            grant <= '0;
            busy  <= 1'b0;
            if (!session_drop) begin
              abort <= NUM_ATM'(1) << winner;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          rr_ptr <= next_ptr;
          if (pick_valid) begin
            state  <= ST_GRANT;
            winner <= pick_idx;
            wd_cnt <= '0;
            grant  <= NUM_ATM'(1) << pick_idx;
            busy   <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
